// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pkg : shared width, access-size and FSM encodings for the LSU |
// | Rev 1.0  initial release                                          |
// +------------------------------------------------------------------+
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    ACC2 = 3'd2,
    RD1  = 3'd3,
    RD2  = 3'd4,
    RSP  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_align : store lane rotate, byte-enable mask, load extension   |
// | Rev 1.0  initial release                                          |
// +------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [2*XLEN-1:0] rdata_i,
  output logic [XLEN-1:0]   qin_o,
  output logic [3:0]        we_lo_o,
  output logic [3:0]        we_hi_o,
  output logic              split_o,
  output logic [XLEN-1:0]   ldata_o
);

  logic [4:0]      w_sh;
  logic [5:0]      w_rsh;
  logic [3:0]      w_mask;
  logic [7:0]      w_lanes;
  logic [XLEN-1:0] w_ld;

  assign w_sh  = {off_i, 3'b000};
  // Left rotate expressed as a right shift of the doubled word.
  assign w_rsh = 6'd32 - {1'b0, w_sh};
  assign qin_o = XLEN'({wdata_i, wdata_i} >> w_rsh);

  always_comb begin
    case (size_i)
      SZ_B:    w_mask = 4'b0001;
      SZ_H:    w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_lanes = {4'b0000, w_mask} << off_i;
  assign we_lo_o = w_lanes[3:0];
  assign we_hi_o = w_lanes[7:4];
  assign split_o = |w_lanes[7:4];

  assign w_ld = XLEN'(rdata_i >> w_sh);

  always_comb begin
    ldata_o = w_ld;
    case (size_i)
      SZ_B:    ldata_o = {{(XLEN-8){~unsigned_i & w_ld[7]}}, w_ld[7:0]};
      SZ_H:    ldata_o = {{(XLEN-16){~unsigned_i & w_ld[15]}}, w_ld[15:0]};
      default: ldata_o = w_ld;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_busif.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_busif : single-outstanding LSU to local-bus bridge, split-aware|
// | Rev 1.0  initial release                                          |
// +------------------------------------------------------------------+
module lsu_busif #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_qin,
  output logic [3:0]      bus_we,
  input  logic [XLEN-1:0] bus_qout
);
  import lsu_pkg::*;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, first_q, first_d;
  logic [XLEN-1:0] rdata_q, rdata_d, baddr_q, baddr_d, bqin_q, bqin_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d, store_q, store_d, split_q, split_d;
  logic [3:0]      bwe_q, bwe_d;

  logic            w_idle;
  logic [1:0]      w_off, w_size;
  logic [XLEN-1:0] w_wdata, w_qin, w_ldata;
  logic [2*XLEN-1:0] w_rdata;
  logic [3:0]      w_we_lo, w_we_hi;
  logic            w_split;

  // While idle the aligner sees the incoming request, afterwards the latched copy.
  assign w_idle  = (state_q == IDLE);
  assign w_off   = w_idle ? req_addr[1:0] : addr_q[1:0];
  assign w_size  = w_idle ? req_size : size_q;
  assign w_wdata = w_idle ? req_wdata : wdata_q;
  assign w_rdata = (state_q == RD2) ? {bus_qout, first_q} : {{XLEN{1'b0}}, bus_qout};

  lsu_align u_align (
    .off_i      (w_off),
    .size_i     (w_size),
    .unsigned_i (uns_q),
    .wdata_i    (w_wdata),
    .rdata_i    (w_rdata),
    .qin_o      (w_qin),
    .we_lo_o    (w_we_lo),
    .we_hi_o    (w_we_hi),
    .split_o    (w_split),
    .ldata_o    (w_ldata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    store_d = store_q;
    wdata_d = wdata_q;
    split_d = split_q;
    first_d = first_q;
    rdata_d = rdata_q;
    baddr_d = '0;
    bqin_d  = '0;
    bwe_d   = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACC1;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          store_d = req_store;
          wdata_d = req_wdata;
          split_d = w_split;
          baddr_d = {req_addr[XLEN-1:2], 2'b00};
          if (req_store) begin
            bqin_d = w_qin;
            bwe_d  = w_we_lo;
          end
        end
      end
      ACC1: begin
        if (split_q) begin
          state_d = ACC2;
          baddr_d = {addr_q[XLEN-1:2] + 1'b1, 2'b00};
          if (store_q) begin
            bqin_d = w_qin;
            bwe_d  = w_we_hi;
          end
        end else if (store_q) begin
          state_d = RSP;
          rdata_d = '0;
        end else begin
          state_d = RD1;
        end
      end
      ACC2: begin
        if (store_q) begin
          state_d = RSP;
          rdata_d = '0;
        end else begin
          state_d = RD2;
          first_d = bus_qout;
        end
      end
      RD1, RD2: begin
        state_d = RSP;
        rdata_d = w_ldata;
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= '0;
      split_q <= 1'b0;
      first_q <= '0;
      rdata_q <= '0;
      baddr_q <= '0;
      bqin_q  <= '0;
      bwe_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      store_q <= store_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      first_q <= first_d;
      rdata_q <= rdata_d;
      baddr_q <= baddr_d;
      bqin_q  <= bqin_d;
      bwe_q   <= bwe_d;
    end
  end

  assign req_ready = w_idle;
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign bus_addr  = baddr_q;
  assign bus_qin   = bqin_q;
  assign bus_we    = bwe_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_busif.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lsu_busif : directed bench with byte-level reference model     |
// | Rev 1.0  initial release                                          |
// +------------------------------------------------------------------+
module tb_lsu_busif;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata, bus_addr, bus_qin, bus_qout;
  logic [3:0]  bus_we;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  lsu_busif #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .bus_addr     (bus_addr),
    .bus_qin      (bus_qin),
    .bus_we       (bus_we),
    .bus_qout     (bus_qout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus-side memory (written by the DUT) and model memory (written by the model).
  logic [31:0] bm [logic [31:0]];
  logic [7:0]  mb [logic [31:0]];

  function automatic logic [31:0] bm_rd(input logic [31:0] a);
    return bm.exists(a) ? bm[a] : 32'h0;
  endfunction

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return mb.exists(a) ? mb[a] : 8'h00;
  endfunction

  initial bus_qout = 32'h0;
  always @(posedge clk) begin
    logic [31:0] w;
    w = bm_rd(bus_addr);
    bus_qout <= w;
    if (bus_we != 4'b0000) begin
      for (int k = 0; k < 4; k++)
        if (bus_we[k]) w[8*k +: 8] = bus_qin[8*k +: 8];
      bm[bus_addr] = w;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bm[a] = d;
    for (int i = 0; i < 4; i++) mb[a + 32'(i)] = d[8*i +: 8];
  endtask

  // Expected per-cycle outputs; absent entries mean the idle values.
  logic [31:0] e_addr [int];
  logic [31:0] e_qin  [int];
  logic [31:0] e_we   [int];
  logic [31:0] e_rsp  [int];
  bit          e_busy [int];
  bit          e_rst  [int];
  logic [31:0] held = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_txn(input bit st, input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] d,
                           input int acc, output int rspc);
    int          nb, off;
    bit          split;
    logic [31:0] wa, q, val, ba;
    logic [7:0]  ln;
    nb    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off   = int'(a[1:0]);
    split = (off + nb) > 4;
    wa    = {a[31:2], 2'b00};
    e_addr[acc] = wa;
    if (split) e_addr[acc+1] = wa + 32'd4;
    if (st) begin
      q  = 32'h0;
      ln = 8'h00;
      for (int i = 0; i < 4; i++) q[8*((off+i)%4) +: 8] = d[8*i +: 8];
      for (int i = 0; i < nb; i++) begin
        ln[off+i] = 1'b1;
        ba = a + 32'(i);
        mb[ba] = d[8*i +: 8];
      end
      e_qin[acc] = q;
      e_we[acc]  = {28'h0, ln[3:0]};
      if (split) begin
        e_qin[acc+1] = q;
        e_we[acc+1]  = {28'h0, ln[7:4]};
      end
      rspc = acc + 1 + int'(split);
      e_rsp[rspc] = 32'h0;
    end else begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) begin
        ba = a + 32'(i);
        val[8*i +: 8] = mbyte(ba);
      end
      if (!u && nb == 1 && val[7])  val[31:8]  = 24'hFFFFFF;
      if (!u && nb == 2 && val[15]) val[31:16] = 16'hFFFF;
      rspc = acc + 2 + int'(split);
      e_rsp[rspc] = val;
    end
    for (int k = acc; k <= rspc; k++) e_busy[k] = 1'b1;
  endtask

  task automatic model_abort(input int c);
    for (int k = c; k < c + 8; k++) begin
      if (e_addr.exists(k)) e_addr.delete(k);
      if (e_qin.exists(k))  e_qin.delete(k);
      if (e_we.exists(k))   e_we.delete(k);
      if (e_rsp.exists(k))  e_rsp.delete(k);
      if (e_busy.exists(k)) e_busy.delete(k);
    end
    e_rst[c] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (e_rst.exists(cyc)) held = 32'h0;
      if (e_rsp.exists(cyc)) held = e_rsp[cyc];
      chk("req_ready", 32'(req_ready), e_busy.exists(cyc) ? 32'h0 : 32'h1);
      chk("rsp_valid", 32'(rsp_valid), e_rsp.exists(cyc) ? 32'h1 : 32'h0);
      chk("rsp_rdata", rsp_rdata, held);
      chk("bus_addr",  bus_addr, e_addr.exists(cyc) ? e_addr[cyc] : 32'h0);
      chk("bus_we",    32'(bus_we), e_we.exists(cyc) ? e_we[cyc] : 32'h0);
      chk("bus_qin",   bus_qin, e_qin.exists(cyc) ? e_qin[cyc] : 32'h0);
    end
  end

  // Present a request for one cycle, then scramble the request inputs.
  task automatic do_req(input bit st, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int acc, output int rspc);
    acc = cyc + 1;
    model_txn(st, sz, u, a, d, acc, rspc);
    req_valid = 1'b1; req_store = st; req_size = sz;
    req_unsigned = u; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid    = 1'b0;
    req_store    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic txn(input bit st, input logic [1:0] sz, input bit u,
                     input logic [31:0] a, input logic [31:0] d);
    int acc, rspc;
    do_req(st, sz, u, a, d, acc, rspc);
    wait_cyc(rspc + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acc, rspc;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_bus_we", 32'(bus_we), 32'h0);

    // Aligned word store
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, acc, rspc);
    chk("sw_addr", bus_addr, 32'h100);
    chk("sw_we", 32'(bus_we), 32'hF);
    chk("sw_qin", bus_qin, 32'hDEADBEEF);
    wait_cyc(acc + 1);
    chk("sw_rsp", 32'(rsp_valid), 32'h1);
    wait_cyc(rspc + 1);

    // Byte store to lane 3
    do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, acc, rspc);
    chk("sb_we", 32'(bus_we), 32'h8);
    chk("sb_qin_hi", 32'(bus_qin[31:24]), 32'hA5);
    wait_cyc(acc + 1);
    chk("sb_we_once", 32'(bus_we), 32'h0);
    wait_cyc(rspc + 1);

    // Split word store
    do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h11223344, acc, rspc);
    chk("ssplit_addr1", bus_addr, 32'h100);
    chk("ssplit_we1", 32'(bus_we), 32'hC);
    chk("ssplit_qin1", bus_qin, 32'h33441122);
    wait_cyc(acc + 1);
    chk("ssplit_addr2", bus_addr, 32'h104);
    chk("ssplit_we2", 32'(bus_we), 32'h3);
    wait_cyc(acc + 2);
    chk("ssplit_rsp", 32'(rsp_valid), 32'h1);
    wait_cyc(rspc + 1);

    // Split signed half loads
    preload(32'h100, 32'h80000000);
    preload(32'h104, 32'h0000007F);
    do_req(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, acc, rspc);
    wait_cyc(acc + 2);
    chk("lh_early", 32'(rsp_valid), 32'h0);
    wait_cyc(acc + 3);
    chk("lh_pos", rsp_rdata, 32'h00007F80);
    wait_cyc(rspc + 1);
    preload(32'h104, 32'h000000FF);
    do_req(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, acc, rspc);
    wait_cyc(acc + 3);
    chk("lh_neg", rsp_rdata, 32'hFFFFFF80);
    wait_cyc(rspc + 1);

    // Wrapping split word load
    preload(32'hFFFFFFFC, 32'hAABBCCDD);
    preload(32'h00000000, 32'h11223344);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, acc, rspc);
    chk("wrap_addr1", bus_addr, 32'hFFFFFFFC);
    wait_cyc(acc + 1);
    chk("wrap_addr2", bus_addr, 32'h0);
    wait_cyc(acc + 3);
    chk("wrap_data", rsp_rdata, 32'h3344AABB);
    wait_cyc(rspc + 1);

    // Mixed sizes, offsets and read-back through the bus memory
    txn(1'b1, 2'b01, 1'b0, 32'h201, 32'hCAFE8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h201, 32'h0, acc, rspc);
    wait_cyc(rspc);
    chk("lhu_rb", rsp_rdata, 32'h00008001);
    wait_cyc(rspc + 1);
    do_req(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, acc, rspc);
    wait_cyc(rspc);
    chk("lh_rb", rsp_rdata, 32'hFFFF8001);
    wait_cyc(rspc + 1);
    txn(1'b0, 2'b00, 1'b0, 32'h202, 32'h0);
    txn(1'b0, 2'b00, 1'b1, 32'h202, 32'h0);
    txn(1'b1, 2'b00, 1'b0, 32'h300, 32'h0000007F);
    txn(1'b1, 2'b11, 1'b0, 32'h304, 32'h12345678);
    txn(1'b0, 2'b11, 1'b0, 32'h304, 32'h0);
    txn(1'b0, 2'b01, 1'b0, 32'h306, 32'h0);
    txn(1'b1, 2'b01, 1'b0, 32'h30B, 32'h0000BEEF);
    txn(1'b0, 2'b01, 1'b1, 32'h30B, 32'h0);
    txn(1'b0, 2'b10, 1'b0, 32'h301, 32'h0);
    txn(1'b0, 2'b10, 1'b0, 32'h309, 32'h0);

    // Reset while the second word of a split store is on the bus
    do_req(1'b1, 2'b10, 1'b0, 32'h401, 32'h55667788, acc, rspc);
    wait_cyc(acc + 1);
    rst = 1'b1;
    model_abort(acc + 2);
    wait_cyc(acc + 2);
    rst = 1'b0;
    chk("rst_we", 32'(bus_we), 32'h0);
    chk("rst_rsp", 32'(rsp_valid), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    wait_cyc(acc + 5);
    chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, acc, rspc);
    wait_cyc(rspc);
    chk("post_rst_ld", rsp_rdata, 32'h66778800);
    wait_cyc(rspc + 3);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_busif.md
LSU_BUSIF -- requirements
Module: lsu_busif

Interface
REQ-001 SHALL have parameter: XLEN, 32, data/address width, fixed at 32.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  core request present.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid&req_ready.
REQ-006 SHALL have port: req_store  input  1  1=store, 0=load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 SHALL have port: req_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
REQ-009 SHALL have port: req_addr  input  XLEN  byte address, any alignment.
REQ-010 SHALL have port: req_wdata  input  XLEN  store data, right-justified.
REQ-011 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: rsp_rdata  output  XLEN  load result, extended; 0 for stores.
REQ-013 SHALL have port: bus_addr  output  XLEN  local bus word address, bits[1:0]=00.
REQ-014 SHALL have port: bus_qin  output  XLEN  local bus write data.
REQ-015 SHALL have port: bus_we  output  4  local bus byte write enables.
REQ-016 SHALL have port: bus_qout  input  XLEN  local bus read data, valid one cycle after bus_addr.

Function
REQ-017 SHALL hold one transaction at a time; req_ready=1 only in IDLE.
REQ-018 SHALL implement FSM: IDLE, ACC1 (first word on bus), ACC2 (second word on bus, split only), RD1 (capture first word), RD2 (capture second word), RSP.
REQ-019 SHALL classify split: word with addr[1:0]!=0, half with addr[1:0]=3; byte never splits.
REQ-020 SHALL register bus_addr/bus_qin/bus_we; in IDLE/RD/RSP bus_we=0000, bus_addr=0, bus_qin=0.
REQ-021 SHALL on accept (cycle N) drive first word: bus_addr={addr[31:2],00} in N+1; second word addr+4 (modulo 2^32, wrap 0xFFFFFFFC->0x00000000) in N+2.
REQ-022 SHALL form store lanes: bus_qin=req_wdata rotated left by 8*addr[1:0]; mask m=0001/0011/1111 for b/h/w; first bus_we=(m<<off)[3:0], second bus_we=(m<<off)[7:4].
REQ-023 SHALL issue store bus_we for exactly one cycle per word, never repeated.
REQ-024 SHALL pulse rsp_valid for stores in the cycle after the last bus_we cycle: aligned N+2, split N+3.
REQ-025 SHALL for loads capture bus_qout one cycle after each address: aligned capture N+2, split captures N+2 and N+3.
REQ-026 SHALL form load data as {second,first} 64-bit shifted right by 8*off, low 8/16/32 bits extended per req_unsigned; rsp_valid aligned load N+3, split N+4.
REQ-027 SHALL latch addr/size/unsigned/wdata on accept; req_* changes afterwards SHALL NOT affect the transaction.
REQ-028 SHALL hold rsp_rdata stable until the next rsp_valid; rsp_valid SHALL be 1 for exactly one cycle.
REQ-029 SHALL return to IDLE from RSP; req_ready reasserts the cycle after rsp_valid.

Reset
REQ-030 SHALL on rst=1 at a clock edge force IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, bus_addr=0, bus_qin=0, bus_we=0000.
REQ-031 SHALL on reset mid-transaction abandon it: no further bus_we, no rsp_valid.

Structure
REQ-032 SHALL place size encodings (SZ_B/SZ_H/SZ_W), FSM state encodings and XLEN in shared package lsu_pkg.
REQ-033 SHALL implement lane rotate, mask generation and load extension in one combinational sub-module lsu_align; FSM and registers stay in lsu_busif.

Verification
REQ-034 SHALL cover aligned word store addr=0x100, wdata=0xDEADBEEF -> N+1 bus_addr=0x100, bus_we=1111, bus_qin=0xDEADBEEF; rsp_valid N+2.
REQ-035 SHALL cover byte store addr=0x103, wdata=0x000000A5 -> bus_we=1000, bus_qin[31:24]=0xA5, single cycle.
REQ-036 SHALL cover split word store addr=0x102, wdata=0x11223344 -> N+1 addr 0x100 we=1100 qin=0x33441122; N+2 addr 0x104 we=0011; rsp_valid N+3.
REQ-037 SHALL cover signed half load addr=0x103, mem[0x100]=0x80xxxxxx, mem[0x104]=0xxxxxxx7F -> rsp_rdata=0x00007F80; same with 0xFF at 0x104 byte0 -> 0xFFFFFF80; rsp_valid N+4.
REQ-038 SHALL cover wrap word load addr=0xFFFFFFFE -> second bus_addr=0x00000000, correct merge.
REQ-039 SHALL cover rst asserted in ACC2 of split store -> bus_we=0000 next cycle, no rsp_valid, req_ready=1 after release.
